// File: rtl/pic_inst_ctrl.sv
// pic_inst_ctrl: instruction register, decoder and Q-phase sequencer for a
// PIC16C5x-style core.
//
// A free-running Q1..Q4 phase counter defines the 4-clock instruction cycle.
// On the edge leaving Q4 the instruction register captures the fetched word
// and the decode fields are registered, so they hold steady for the whole
// following cycle. Write, status, PC and stack strobes are qualified with Q4.
// Branches (GOTO/CALL/RETLW) and taken skips (DECFSZ/INCFSZ/BTFSC/BTFSS) set
// a flush flag that turns the next, already-prefetched instruction into a NOP.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instIn              program memory word at the current PC
//   resultZeroIn        ALU result == 0 for the executing instruction
//   fBitIn              selected file-register bit for BTFSC/BTFSS
//   qPhaseOut           0..3 = Q1..Q4
//   aluFuncOut          ALU function code
//   bitSelOut, litOut, fAddrOut   instruction fields [7:5], [7:0], [4:0]
//   fSrcSelOut, wZeroOut          ALU operand selects
//   wWeOut, fWeOut, statusWeOut   Q4 write strobes / status update mask
//   pcIncOut, pcLoadOut, pcSrcOut, pcTargetOut   program counter control
//   stackPushOut, stackPopOut     call stack control

`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef BIT_SEL_WIDTH
`define BIT_SEL_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ALU_STATUS_WIDTH
`define ALU_STATUS_WIDTH 3
`endif
`ifndef ALU_IDLE
`define ALU_IDLE  4'd0
`define ALU_ADDWF 4'd1
`define ALU_SUBWF 4'd2
`define ALU_ANDWF 4'd3
`define ALU_IORWF 4'd4
`define ALU_XORWF 4'd5
`define ALU_COMF  4'd6
`define ALU_DECF  4'd7
`define ALU_INCF  4'd8
`define ALU_RRF   4'd9
`define ALU_RLF   4'd10
`define ALU_SWAPF 4'd11
`define ALU_BCF   4'd12
`define ALU_BSF   4'd13
`define ALU_IORLW 4'd14
`define ALU_ANDLW 4'd15
`endif

module pic_inst_ctrl #(
  parameter int INST_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INST_WIDTH-1:0]        instIn,
  input  logic                         resultZeroIn,
  input  logic                         fBitIn,
  output logic [1:0]                   qPhaseOut,
  output logic [`ALU_FUNC_WIDTH-1:0]   aluFuncOut,
  output logic [`BIT_SEL_WIDTH-1:0]    bitSelOut,
  output logic [`DATA_WIDTH-1:0]       litOut,
  output logic [4:0]                   fAddrOut,
  output logic [1:0]                   fSrcSelOut,
  output logic                         wZeroOut,
  output logic                         wWeOut,
  output logic                         fWeOut,
  output logic [`ALU_STATUS_WIDTH-1:0] statusWeOut,
  output logic                         pcIncOut,
  output logic                         pcLoadOut,
  output logic                         pcSrcOut,
  output logic [8:0]                   pcTargetOut,
  output logic                         stackPushOut,
  output logic                         stackPopOut
);

  localparam logic [1:0] PH_Q4 = 2'd3;

  // State
  logic [1:0]                   phase_q, phase_d;
  logic [INST_WIDTH-1:0]        ir_q, ir_d;
  logic                         flush_q, flush_d;
  logic [`ALU_FUNC_WIDTH-1:0]   func_q, func_d;
  logic [1:0]                   fsrc_q, fsrc_d;
  logic                         wzero_q, wzero_d;
  logic                         w_we_q, w_we_d;
  logic                         f_we_q, f_we_d;
  logic [`ALU_STATUS_WIDTH-1:0] status_q, status_d;
  logic                         pc_load_q, pc_load_d;
  logic                         pc_src_q, pc_src_d;
  logic                         push_q, push_d;
  logic                         pop_q, pop_d;
  logic [8:0]                   target_q, target_d;

  // Decode of the incoming word
  logic [`ALU_FUNC_WIDTH-1:0]   dec_func;
  logic [1:0]                   dec_fsrc;
  logic                         dec_wzero, dec_w_we, dec_f_we;
  logic [`ALU_STATUS_WIDTH-1:0] dec_status;
  logic                         dec_load, dec_src, dec_push, dec_pop;
  logic [8:0]                   dec_target;
  logic                         file_dest;

  // Redirect decision for the instruction currently executing
  logic skip_z, skip_taken, branch, redirect;
  logic leave_q4, q4;

  always_comb begin
    dec_func   = `ALU_IDLE;
    dec_fsrc   = 2'd0;
    dec_wzero  = 1'b0;
    dec_w_we   = 1'b0;
    dec_f_we   = 1'b0;
    dec_status = '0;
    dec_load   = 1'b0;
    dec_src    = 1'b0;
    dec_push   = 1'b0;
    dec_pop    = 1'b0;
    dec_target = instIn[8:0];
    file_dest  = 1'b0;
    case (instIn[11:8])
      4'h0, 4'h1, 4'h2, 4'h3: begin
        // Byte-oriented group: bit 5 (d) chooses W or the file register.
        file_dest = 1'b1;
        case (instIn[11:6])
          6'b000000: begin
            // 0x020-0x03F is MOVWF; the rest of this block are no-write ops.
            file_dest = 1'b0;
            if (instIn[5]) begin
              dec_func = `ALU_IORWF;
              dec_fsrc = 2'd2;
              dec_f_we = 1'b1;
            end
          end
          6'b000001: dec_status = 3'b100;  // CLRW (d=0) / CLRF (d=1)
          6'b000010: begin dec_func = `ALU_SUBWF; dec_status = 3'b111; end
          6'b000011: begin dec_func = `ALU_DECF;  dec_status = 3'b100; end
          6'b000100: begin dec_func = `ALU_IORWF; dec_status = 3'b100; end
          6'b000101: begin dec_func = `ALU_ANDWF; dec_status = 3'b100; end
          6'b000110: begin dec_func = `ALU_XORWF; dec_status = 3'b100; end
          6'b000111: begin dec_func = `ALU_ADDWF; dec_status = 3'b111; end
          6'b001000: begin
            // MOVF: 0 | f passes f through and still updates Z.
            dec_func = `ALU_IORWF; dec_wzero = 1'b1; dec_status = 3'b100;
          end
          6'b001001: begin dec_func = `ALU_COMF;  dec_status = 3'b100; end
          6'b001010: begin dec_func = `ALU_INCF;  dec_status = 3'b100; end
          6'b001011: dec_func = `ALU_DECF;   // DECFSZ
          6'b001100: begin dec_func = `ALU_RRF;   dec_status = 3'b001; end
          6'b001101: begin dec_func = `ALU_RLF;   dec_status = 3'b001; end
          6'b001110: dec_func = `ALU_SWAPF;
          6'b001111: dec_func = `ALU_INCF;   // INCFSZ
          default: ;
        endcase
      end
      4'h4: begin dec_func = `ALU_BCF; dec_f_we = 1'b1; end
      4'h5: begin dec_func = `ALU_BSF; dec_f_we = 1'b1; end
      4'h8: begin  // RETLW: W <= literal, return through stack top
        dec_func = `ALU_IORLW; dec_wzero = 1'b1; dec_w_we = 1'b1;
        dec_pop = 1'b1; dec_load = 1'b1; dec_src = 1'b1;
      end
      4'h9: begin  // CALL only reaches the lower half of each page
        dec_push = 1'b1; dec_load = 1'b1; dec_target = {1'b0, instIn[7:0]};
      end
      4'hA, 4'hB: dec_load = 1'b1;  // GOTO
      4'hC: begin dec_func = `ALU_IORLW; dec_wzero = 1'b1; dec_w_we = 1'b1; end
      4'hD: begin dec_func = `ALU_IORLW; dec_w_we = 1'b1; dec_status = 3'b100; end
      4'hE: begin dec_func = `ALU_ANDLW; dec_w_we = 1'b1; dec_status = 3'b100; end
      4'hF: begin
        dec_func = `ALU_XORWF; dec_fsrc = 2'd1; dec_w_we = 1'b1; dec_status = 3'b100;
      end
      default: ;  // BTFSC / BTFSS: test only, no writes
    endcase
    if (file_dest) begin
      dec_w_we = ~instIn[5];
      dec_f_we = instIn[5];
    end
  end

  // A flushed instruction is a NOP, so it can neither skip nor branch.
  always_comb begin
    skip_z     = (ir_q[11:6] == 6'b001011) || (ir_q[11:6] == 6'b001111);
    skip_taken = (skip_z && resultZeroIn) ||
                 ((ir_q[11:8] == 4'h6) && !fBitIn) ||
                 ((ir_q[11:8] == 4'h7) && fBitIn);
    branch     = (ir_q[11:10] == 2'b10);
    redirect   = !flush_q && (skip_taken || branch);
  end

  // Next-state logic: everything except the phase advances only leaving Q4.
  always_comb begin
    leave_q4  = (phase_q == PH_Q4);
    phase_d   = phase_q + 2'd1;
    ir_d      = ir_q;
    flush_d   = flush_q;
    func_d    = func_q;
    fsrc_d    = fsrc_q;
    wzero_d   = wzero_q;
    w_we_d    = w_we_q;
    f_we_d    = f_we_q;
    status_d  = status_q;
    pc_load_d = pc_load_q;
    pc_src_d  = pc_src_q;
    push_d    = push_q;
    pop_d     = pop_q;
    target_d  = target_q;
    if (leave_q4) begin
      ir_d      = instIn;
      flush_d   = redirect;
      target_d  = dec_target;
      func_d    = redirect ? `ALU_IDLE : dec_func;
      fsrc_d    = redirect ? 2'd0 : dec_fsrc;
      wzero_d   = !redirect && dec_wzero;
      w_we_d    = !redirect && dec_w_we;
      f_we_d    = !redirect && dec_f_we;
      status_d  = redirect ? '0 : dec_status;
      pc_load_d = !redirect && dec_load;
      pc_src_d  = !redirect && dec_src;
      push_d    = !redirect && dec_push;
      pop_d     = !redirect && dec_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= 2'd0;
      ir_q      <= '0;
      flush_q   <= 1'b1;  // reset-vector word is still being fetched
      func_q    <= `ALU_IDLE;
      fsrc_q    <= 2'd0;
      wzero_q   <= 1'b0;
      w_we_q    <= 1'b0;
      f_we_q    <= 1'b0;
      status_q  <= '0;
      pc_load_q <= 1'b0;
      pc_src_q  <= 1'b0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      target_q  <= 9'd0;
    end else begin
      phase_q   <= phase_d;
      ir_q      <= ir_d;
      flush_q   <= flush_d;
      func_q    <= func_d;
      fsrc_q    <= fsrc_d;
      wzero_q   <= wzero_d;
      w_we_q    <= w_we_d;
      f_we_q    <= f_we_d;
      status_q  <= status_d;
      pc_load_q <= pc_load_d;
      pc_src_q  <= pc_src_d;
      push_q    <= push_d;
      pop_q     <= pop_d;
      target_q  <= target_d;
    end
  end

  // Outputs: held decode fields plus Q4-qualified strobes.
  always_comb begin
    q4           = (phase_q == PH_Q4);
    qPhaseOut    = phase_q;
    aluFuncOut   = func_q;
    bitSelOut    = ir_q[7:5];
    litOut       = ir_q[7:0];
    fAddrOut     = ir_q[4:0];
    fSrcSelOut   = fsrc_q;
    wZeroOut     = wzero_q;
    pcTargetOut  = target_q;
    wWeOut       = q4 && w_we_q;
    fWeOut       = q4 && f_we_q;
    statusWeOut  = q4 ? status_q : '0;
    pcLoadOut    = q4 && pc_load_q;
    pcSrcOut     = q4 && pc_src_q;
    stackPushOut = q4 && push_q;
    stackPopOut  = q4 && pop_q;
    pcIncOut     = q4 && !pc_load_q;
  end

endmodule

// File: tb/tb_pic_inst_ctrl.sv
// Testbench for pic_inst_ctrl: directed test-plan sequence followed by random
// instruction streams, checked every clock against an instruction-level model.

`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef BIT_SEL_WIDTH
`define BIT_SEL_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ALU_STATUS_WIDTH
`define ALU_STATUS_WIDTH 3
`endif
`ifndef ALU_IDLE
`define ALU_IDLE  4'd0
`define ALU_ADDWF 4'd1
`define ALU_SUBWF 4'd2
`define ALU_ANDWF 4'd3
`define ALU_IORWF 4'd4
`define ALU_XORWF 4'd5
`define ALU_COMF  4'd6
`define ALU_DECF  4'd7
`define ALU_INCF  4'd8
`define ALU_RRF   4'd9
`define ALU_RLF   4'd10
`define ALU_SWAPF 4'd11
`define ALU_BCF   4'd12
`define ALU_BSF   4'd13
`define ALU_IORLW 4'd14
`define ALU_ANDLW 4'd15
`endif

module tb_pic_inst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] instIn = 12'h000;
  logic        resultZeroIn = 1'b0;
  logic        fBitIn = 1'b0;
  logic [1:0]  qPhaseOut;
  logic [`ALU_FUNC_WIDTH-1:0]   aluFuncOut;
  logic [`BIT_SEL_WIDTH-1:0]    bitSelOut;
  logic [`DATA_WIDTH-1:0]       litOut;
  logic [4:0]  fAddrOut;
  logic [1:0]  fSrcSelOut;
  logic        wZeroOut, wWeOut, fWeOut;
  logic [`ALU_STATUS_WIDTH-1:0] statusWeOut;
  logic        pcIncOut, pcLoadOut, pcSrcOut;
  logic [8:0]  pcTargetOut;
  logic        stackPushOut, stackPopOut;

  always #5 clk = ~clk;

  pic_inst_ctrl #(.INST_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .instIn(instIn), .resultZeroIn(resultZeroIn),
    .fBitIn(fBitIn), .qPhaseOut(qPhaseOut), .aluFuncOut(aluFuncOut),
    .bitSelOut(bitSelOut), .litOut(litOut), .fAddrOut(fAddrOut),
    .fSrcSelOut(fSrcSelOut), .wZeroOut(wZeroOut), .wWeOut(wWeOut),
    .fWeOut(fWeOut), .statusWeOut(statusWeOut), .pcIncOut(pcIncOut),
    .pcLoadOut(pcLoadOut), .pcSrcOut(pcSrcOut), .pcTargetOut(pcTargetOut),
    .stackPushOut(stackPushOut), .stackPopOut(stackPopOut)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {
    M_NOP, M_MOVWF, M_CLRW, M_CLRF, M_SUBWF, M_DECF, M_IORWF, M_ANDWF,
    M_XORWF, M_ADDWF, M_MOVF, M_COMF, M_INCF, M_DECFSZ, M_RRF, M_RLF,
    M_SWAPF, M_INCFSZ, M_BCF, M_BSF, M_BTFSC, M_BTFSS, M_RETLW, M_CALL,
    M_GOTO, M_MOVLW, M_IORLW, M_ANDLW, M_XORLW
  } mnem_e;

  typedef struct packed {
    logic [3:0] func;
    logic [1:0] fsrc;
    logic       wzero, we_w, we_f;
    logic [2:0] status;
    logic       load, src, push, pop, has_target;
    logic [8:0] target;
  } exp_t;

  // PIC16C5x instruction set map.
  function automatic mnem_e classify(input logic [11:0] w);
    casez (w)
      12'b0000_000?_????: return M_NOP;
      12'b0000_001?_????: return M_MOVWF;
      12'b0000_010?_????: return M_CLRW;
      12'b0000_011?_????: return M_CLRF;
      12'b0000_10??_????: return M_SUBWF;
      12'b0000_11??_????: return M_DECF;
      12'b0001_00??_????: return M_IORWF;
      12'b0001_01??_????: return M_ANDWF;
      12'b0001_10??_????: return M_XORWF;
      12'b0001_11??_????: return M_ADDWF;
      12'b0010_00??_????: return M_MOVF;
      12'b0010_01??_????: return M_COMF;
      12'b0010_10??_????: return M_INCF;
      12'b0010_11??_????: return M_DECFSZ;
      12'b0011_00??_????: return M_RRF;
      12'b0011_01??_????: return M_RLF;
      12'b0011_10??_????: return M_SWAPF;
      12'b0011_11??_????: return M_INCFSZ;
      12'b0100_????_????: return M_BCF;
      12'b0101_????_????: return M_BSF;
      12'b0110_????_????: return M_BTFSC;
      12'b0111_????_????: return M_BTFSS;
      12'b1000_????_????: return M_RETLW;
      12'b1001_????_????: return M_CALL;
      12'b101?_????_????: return M_GOTO;
      12'b1100_????_????: return M_MOVLW;
      12'b1101_????_????: return M_IORLW;
      12'b1110_????_????: return M_ANDLW;
      default:            return M_XORLW;
    endcase
  endfunction

  // What a non-flushed instruction must drive.
  function automatic exp_t expect_of(input logic [11:0] w);
    exp_t e;
    logic fop;
    e = '0;
    e.func = `ALU_IDLE;
    fop = 1'b0;
    case (classify(w))
      M_SUBWF:  begin e.func = `ALU_SUBWF; e.status = 3'b111; fop = 1'b1; end
      M_ADDWF:  begin e.func = `ALU_ADDWF; e.status = 3'b111; fop = 1'b1; end
      M_ANDWF:  begin e.func = `ALU_ANDWF; e.status = 3'b100; fop = 1'b1; end
      M_IORWF:  begin e.func = `ALU_IORWF; e.status = 3'b100; fop = 1'b1; end
      M_XORWF:  begin e.func = `ALU_XORWF; e.status = 3'b100; fop = 1'b1; end
      M_COMF:   begin e.func = `ALU_COMF;  e.status = 3'b100; fop = 1'b1; end
      M_DECF:   begin e.func = `ALU_DECF;  e.status = 3'b100; fop = 1'b1; end
      M_INCF:   begin e.func = `ALU_INCF;  e.status = 3'b100; fop = 1'b1; end
      M_RRF:    begin e.func = `ALU_RRF;   e.status = 3'b001; fop = 1'b1; end
      M_RLF:    begin e.func = `ALU_RLF;   e.status = 3'b001; fop = 1'b1; end
      M_SWAPF:  begin e.func = `ALU_SWAPF; fop = 1'b1; end
      M_MOVF:   begin e.func = `ALU_IORWF; e.wzero = 1'b1; e.status = 3'b100; fop = 1'b1; end
      M_MOVWF:  begin e.func = `ALU_IORWF; e.fsrc = 2'd2; e.we_f = 1'b1; end
      M_CLRF:   begin e.we_f = 1'b1; e.status = 3'b100; end
      M_CLRW:   begin e.we_w = 1'b1; e.status = 3'b100; end
      M_DECFSZ: begin e.func = `ALU_DECF; fop = 1'b1; end
      M_INCFSZ: begin e.func = `ALU_INCF; fop = 1'b1; end
      M_BCF:    begin e.func = `ALU_BCF; e.we_f = 1'b1; end
      M_BSF:    begin e.func = `ALU_BSF; e.we_f = 1'b1; end
      M_MOVLW:  begin e.func = `ALU_IORLW; e.wzero = 1'b1; e.we_w = 1'b1; end
      M_IORLW:  begin e.func = `ALU_IORLW; e.we_w = 1'b1; e.status = 3'b100; end
      M_ANDLW:  begin e.func = `ALU_ANDLW; e.we_w = 1'b1; e.status = 3'b100; end
      M_XORLW:  begin e.func = `ALU_XORWF; e.fsrc = 2'd1; e.we_w = 1'b1; e.status = 3'b100; end
      M_GOTO:   begin e.load = 1'b1; e.has_target = 1'b1; e.target = w[8:0]; end
      M_CALL:   begin e.load = 1'b1; e.push = 1'b1; e.has_target = 1'b1; e.target = {1'b0, w[7:0]}; end
      M_RETLW:  begin
        e.load = 1'b1; e.src = 1'b1; e.pop = 1'b1;
        e.func = `ALU_IORLW; e.wzero = 1'b1; e.we_w = 1'b1;
      end
      default: ;
    endcase
    if (fop) begin
      e.we_w = !w[5];
      e.we_f = w[5];
    end
    return e;
  endfunction

  function automatic logic takes_skip(input logic [11:0] w, input logic rz, input logic fb);
    mnem_e m;
    m = classify(w);
    return ((m == M_DECFSZ || m == M_INCFSZ) && rz) ||
           (m == M_BTFSC && !fb) || (m == M_BTFSS && fb);
  endfunction

  // Model state: word executing this instruction cycle, and whether it is killed.
  logic [11:0] m_exec   = 12'h000;
  logic        m_killed = 1'b1;

  // Q4 snapshot of DUT outputs for the literal pins.
  logic [3:0] s_func;
  logic [7:0] s_lit;
  logic [4:0] s_faddr;
  logic [2:0] s_status;
  logic [8:0] s_target;
  logic       s_wwe, s_fwe, s_wzero, s_load, s_src, s_inc, s_push, s_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h exec=%03h t=%0t", name, act, exp, m_exec, $time);
    end
  endtask

  task automatic check_clock(input int p);
    exp_t e;
    logic q4, act;
    e   = expect_of(m_exec);
    q4  = (p == 3);
    act = q4 && !m_killed;
    chk("qPhase", qPhaseOut, p);
    chk("aluFunc", aluFuncOut, m_killed ? `ALU_IDLE : e.func);
    if (!m_killed) begin
      chk("lit", litOut, m_exec[7:0]);
      chk("bitSel", bitSelOut, m_exec[7:5]);
      chk("fAddr", fAddrOut, m_exec[4:0]);
      chk("fSrcSel", fSrcSelOut, e.fsrc);
      chk("wZero", wZeroOut, e.wzero);
      if (e.has_target) chk("pcTarget", pcTargetOut, e.target);
    end
    chk("wWe", wWeOut, act && e.we_w);
    chk("fWe", fWeOut, act && e.we_f);
    chk("statusWe", statusWeOut, act ? e.status : 3'b000);
    chk("pcLoad", pcLoadOut, act && e.load);
    chk("pcSrc", pcSrcOut, act && e.src);
    chk("stackPush", stackPushOut, act && e.push);
    chk("stackPop", stackPopOut, act && e.pop);
    chk("pcInc", pcIncOut, q4 && !(act && e.load));
  endtask

  // rst is sampled at the next rising edge; checked at the following falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    m_exec   = 12'h000;
    m_killed = 1'b1;
    check_clock(0);
    chk("rst_lit", litOut, 0);
    chk("rst_fAddr", fAddrOut, 0);
    chk("rst_pcTarget", pcTargetOut, 0);
    chk("rst_fSrcSel", fSrcSelOut, 0);
    chk("rst_wZero", wZeroOut, 0);
    rst = 1'b0;
  endtask

  // One instruction cycle: fetch word 'inst' while the model's m_exec executes.
  // rst_at >= 0 asserts rst after checking that phase, aborting the cycle.
  task automatic run_cycle(input logic [11:0] inst, input logic rz, input logic fb, input int rst_at);
    logic redirect;
    for (int p = 0; p < 4; p++) begin
      check_clock(p);
      if (p == 0) begin
        instIn = inst;
        resultZeroIn = rz;
        fBitIn = fb;
      end
      if (p == 3) begin
        s_func = aluFuncOut; s_lit = litOut; s_faddr = fAddrOut;
        s_status = statusWeOut; s_target = pcTargetOut; s_wwe = wWeOut;
        s_fwe = fWeOut; s_wzero = wZeroOut; s_load = pcLoadOut;
        s_src = pcSrcOut; s_inc = pcIncOut; s_push = stackPushOut; s_pop = stackPopOut;
      end
      if (p == rst_at) begin
        $display("cycle exec=%03h fetch=%03h reset asserted in Q%0d", m_exec, inst, p + 1);
        do_reset();
        return;
      end
      @(negedge clk);
    end
    redirect = !m_killed && (expect_of(m_exec).load || takes_skip(m_exec, rz, fb));
    $display("cycle exec=%03h%s fetch=%03h rz=%0d fb=%0d redirect=%0d",
             m_exec, m_killed ? "(flushed)" : "", inst, rz, fb, redirect);
    m_killed = redirect;
    m_exec   = inst;
  endtask

  initial begin
    do_reset();
    // Flushed reset cycle while MOVLW 0x2A is fetched.
    run_cycle(12'hC2A, 1'b0, 1'b0, -1);
    chk("pin_c1_wWe", s_wwe, 0);
    chk("pin_c1_func", s_func, `ALU_IDLE);
    chk("pin_c1_pcInc", s_inc, 1);
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // executes MOVLW 0x2A
    chk("pin_movlw_func", s_func, `ALU_IORLW);
    chk("pin_movlw_lit", s_lit, 8'h2A);
    chk("pin_movlw_wZero", s_wzero, 1);
    chk("pin_movlw_wWe", s_wwe, 1);
    chk("pin_movlw_status", s_status, 3'b000);
    run_cycle(12'hAA5, 1'b0, 1'b0, -1);  // executes ADDWF 7,W
    chk("pin_addwf_func", s_func, `ALU_ADDWF);
    chk("pin_addwf_fAddr", s_faddr, 5'd7);
    chk("pin_addwf_wWe", s_wwe, 1);
    chk("pin_addwf_fWe", s_fwe, 0);
    chk("pin_addwf_status", s_status, 3'b111);
    chk("pin_addwf_pcInc", s_inc, 1);
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // executes GOTO 0x0A5
    chk("pin_goto_pcLoad", s_load, 1);
    chk("pin_goto_pcSrc", s_src, 0);
    chk("pin_goto_target", s_target, 9'h0A5);
    chk("pin_goto_pcInc", s_inc, 0);
    run_cycle(12'h2F0, 1'b0, 1'b0, -1);  // ADDWF flushed after GOTO
    chk("pin_flush_wWe", s_wwe, 0);
    chk("pin_flush_status", s_status, 3'b000);
    chk("pin_flush_pcInc", s_inc, 1);
    run_cycle(12'h1C7, 1'b1, 1'b0, -1);  // DECFSZ 0x10,F with zero result: skip
    chk("pin_decfsz_fWe", s_fwe, 1);
    run_cycle(12'h2F0, 1'b0, 1'b0, -1);  // skipped ADDWF
    chk("pin_skip_wWe", s_wwe, 0);
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // DECFSZ, non-zero: no skip
    run_cycle(12'h7E3, 1'b0, 1'b0, -1);  // ADDWF runs
    chk("pin_noskip_wWe", s_wwe, 1);
    run_cycle(12'h1C7, 1'b0, 1'b1, -1);  // BTFSS 3,7 with bit set: skip
    run_cycle(12'h7E3, 1'b0, 1'b0, -1);  // skipped ADDWF
    chk("pin_btfss_skip_wWe", s_wwe, 0);
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // BTFSS with bit clear: no skip
    run_cycle(12'h950, 1'b0, 1'b0, -1);  // ADDWF runs
    chk("pin_btfss_noskip_wWe", s_wwe, 1);
    run_cycle(12'h855, 1'b0, 1'b0, -1);  // CALL 0x50
    chk("pin_call_push", s_push, 1);
    chk("pin_call_target", s_target, 9'h050);
    chk("pin_call_pcLoad", s_load, 1);
    run_cycle(12'h855, 1'b0, 1'b0, -1);  // flushed after CALL
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // RETLW 0x55
    chk("pin_retlw_pop", s_pop, 1);
    chk("pin_retlw_pcSrc", s_src, 1);
    chk("pin_retlw_wWe", s_wwe, 1);
    chk("pin_retlw_lit", s_lit, 8'h55);
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // flushed after RETLW
    run_cycle(12'h1C7, 1'b0, 1'b0, 2);   // ADDWF interrupted by rst in Q3
    chk("pin_midrst_phase", qPhaseOut, 2'd0);
    chk("pin_midrst_func", aluFuncOut, `ALU_IDLE);
    run_cycle(12'h1C7, 1'b0, 1'b0, -1);  // flushed cycle after reset
    chk("pin_midrst_flush_wWe", s_wwe, 0);

    for (int i = 0; i < 400; i++) begin
      logic [11:0] w;
      int ra;
      w  = 12'($urandom_range(0, 4095));
      ra = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cycle(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_inst_ctrl.md
# pic_inst_ctrl

Instruction decoder and Q-phase sequencer for the PIC16C5x core. It holds the 12-bit instruction register and drives the ALU function code, bit select, literal and operand selects toward the ALU and datapath. It also produces the write enables, status-update mask and program-counter/stack controls once per 4-clock instruction cycle. It implements GOTO/CALL/RETLW redirection and the conditional skips (DECFSZ, INCFSZ, BTFSC, BTFSS) by flushing the prefetched instruction.

## Interface
- INST_WIDTH, 12, instruction word width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instIn  in  INST_WIDTH  word from program memory at the current PC; sampled on the edge leaving Q4
- resultZeroIn  in  1  ALU result == 0; sampled on the edge leaving Q4
- fBitIn  in  1  fIn[bitSelOut] from datapath; sampled on the edge leaving Q4
- qPhaseOut  out  2  phase 0..3 = Q1..Q4
- aluFuncOut  out  `ALU_FUNC_WIDTH  ALU function code (define.v encodings)
- bitSelOut  out  `BIT_SEL_WIDTH  instruction bits [7:5]
- litOut  out  `DATA_WIDTH  instruction bits [7:0]
- fAddrOut  out  5  instruction bits [4:0]
- fSrcSelOut  out  2  ALU fIn source: 0 = register file, 1 = literal, 2 = zero
- wZeroOut  out  1  force ALU WIn to 0
- wWeOut, fWeOut  out  1 each  write result to W / to file register
- statusWeOut  out  `ALU_STATUS_WIDTH  update mask {Z, DC, C}
- pcIncOut  out  1  PC += 1
- pcLoadOut  out  1  load PC
- pcSrcOut  out  1  0 = pcTargetOut, 1 = stack top
- pcTargetOut  out  9  branch target
- stackPushOut, stackPopOut  out  1 each  call stack push / pop

## Operation
- Phase counter: Q1→Q2→Q3→Q4→Q1, free-running; one instruction cycle = 4 clocks.
- IR loads instIn on the edge leaving Q4. Decode outputs are registered from IR on the same edge and hold stable through Q1..Q4: aluFunc, bitSel, lit, fAddr, fSrcSel, wZero, pcTarget.
- d = IR[5]: d=0 → wWe, d=1 → fWe.
- Mapping; opcode → func / fSrcSel / wZero / status mask:
  - SUBWF, ADDWF → SUBWF, ADDWF / 0 / 0 / 111.
  - ANDWF, IORWF, XORWF, COMF, DECF, INCF → same name / 0 / 0 / 100.
  - RRF, RLF → same name / 0 / 0 / 001.
  - SWAPF → SWAPF / 0 / 0 / 000.
  - MOVF → IORWF / 0 / 1 / 100.
  - MOVWF → IORWF / 2 / 0 / 000; fWe.
  - CLRF → IDLE; fWe; 100. CLRW → IDLE; wWe; 100.
  - DECFSZ, INCFSZ → DECF, INCF / 0 / 0 / 000; skip if resultZeroIn.
  - BCF, BSF → same name; fWe; 000.
  - BTFSC, BTFSS → IDLE; no writes; skip if fBitIn==0 / ==1.
  - MOVLW → IORLW, wZero; wWe; 000.
  - IORLW, ANDLW → same name; wWe; 100.
  - XORLW → XORWF, fSrcSel=1; wWe; 100.
  - GOTO → pcLoad, pcSrc=0, target = IR[8:0].
  - CALL → stackPush, pcLoad, target = {0, IR[7:0]}.
  - RETLW → stackPop, pcLoad, pcSrc=1, IORLW + wZero, wWe.
  - NOP and all other 0x000-0x00F words (OPTION, SLEEP, CLRWDT, TRIS) → IDLE, no enables.
- Flush flag: set on the edge leaving Q4 when the executing instruction is GOTO/CALL/RETLW or a skip is taken. The following cycle executes as NOP: IDLE, all write/status/stack/pcLoad enables 0. The flag clears at that cycle's end. A flushed skip instruction never sets the flag.

## Timing
- Reset (rst high at an edge) forces: qPhaseOut=Q1, IR=0x000, flush=1, aluFuncOut=`ALU_IDLE`, every other output 0. The first cycle after reset is a flushed NOP while the reset-vector word is fetched.
- wWeOut, fWeOut, statusWeOut, pcLoadOut, pcSrcOut, stackPushOut, stackPopOut: high only during the single clock with qPhaseOut==Q4.
- pcIncOut: high during Q4 of every cycle (including flushed cycles) except when pcLoadOut is high.
- rst asserted mid-cycle: next edge returns to reset state; no enable is asserted in the clock following a sampled rst.
- Decode latency: instruction fetched in cycle n executes in cycle n+1. The skip/branch decision of cycle n kills cycle n+1.

## Test plan
- Reset, then IR=0xC2A (MOVLW 0x2A) → cycle 1 all enables 0. Cycle 2: aluFunc=IORLW, lit=0x2A, wZero=1, wWe pulse in Q4, statusWe=000.
- 0x1C7 (ADDWF 7,W) → aluFunc=ADDWF, fAddr=7, fSrcSel=0, Q4: wWe=1, fWe=0, statusWe=111, pcInc=1.
- 0xAA5 (GOTO 0x0A5) → Q4: pcLoad=1, pcSrc=0, pcTarget=0x0A5, pcInc=0. Next instruction (0x1C7) runs flushed with no enables, pcInc=1.
- 0x2F0 (DECFSZ 0x10,F) with resultZeroIn=1 → fWe in Q4, next cycle flushed. Repeat with resultZeroIn=0 → next executes normally. 0x7E3 (BTFSS 3,7) with fBitIn=1 → skip; fBitIn=0 → no skip.
- 0x950 (CALL 0x50) then 0x855 (RETLW 0x55) → CALL: stackPush, target 0x050, flush. RETLW: stackPop, pcSrc=1, wWe, lit=0x55, flush.
- rst pulsed during Q3 of an ADDWF cycle → no wWe/statusWe pulse; qPhaseOut=Q1 and aluFunc=IDLE on the next clock; one flushed cycle follows.
